// File: rtl/polar_sm_conv_pipe.sv
// Two-stage valid/ready converter between two's-complement and sign-magnitude LLR lanes.
// Direction is chosen per beat; the 2C minimum saturates to the largest SM negative.
module polar_sm_conv_pipe #(
    parameter int unsigned W     = 9,
    parameter int unsigned LANES = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [LANES*W-1:0]   s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [LANES*W-1:0]   m_data,
    output logic [LANES-1:0]     m_sat,
    input  logic                 clr_cnt,
    output logic [CNT_W-1:0]     sat_cnt
);

    localparam int unsigned DW    = LANES * W;
    localparam int unsigned PC_W  = $clog2(LANES + 1);
    localparam int unsigned SUM_W = CNT_W + PC_W;

    logic             s1_valid_q;
    logic [DW-1:0]    s1_data_q;
    logic             s1_mode_q;
    logic             s2_valid_q;
    logic [DW-1:0]    s2_data_q, s2_data_d;
    logic [LANES-1:0] s2_sat_q, s2_sat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s1_load, s2_load;
    logic [PC_W-1:0]  pc;
    logic [SUM_W-1:0] sum;

    // Returns {sat, converted lane}.
    function automatic logic [W:0] conv_lane(input logic [W-1:0] x, input logic md);
        logic [W-1:0] res;
        logic [W-1:0] tmp;
        logic         sat;
        sat = 1'b0;
        res = x;
        if (x[W-1]) begin
            if (!md) begin
                if (x[W-2:0] == '0) begin
                    res = '1;
                    sat = 1'b1;
                end else begin
                    tmp = -x;
                    res = {1'b1, tmp[W-2:0]};
                end
            end else begin
                tmp = {1'b0, x[W-2:0]};
                res = '0 - tmp;
            end
        end
        return {sat, res};
    endfunction

    assign s2_load = s1_valid_q & (~s2_valid_q | m_ready);
    assign s_ready = ~s1_valid_q | s2_load;
    assign s1_load = s_valid & s_ready;

    always_comb begin
        s2_data_d = '0;
        s2_sat_d  = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            {s2_sat_d[i], s2_data_d[i*W +: W]} = conv_lane(s1_data_q[i*W +: W], s1_mode_q);
        end
    end

    // Saturating event counter; clear has priority over a coincident handshake.
    always_comb begin
        pc = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            pc = pc + PC_W'(s2_sat_q[i]);
        end
        sum   = SUM_W'(cnt_q) + SUM_W'(pc);
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (s2_valid_q && m_ready) begin
            cnt_d = (sum > SUM_W'({CNT_W{1'b1}})) ? '1 : CNT_W'(sum);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mode_q  <= 1'b0;
        end else if (s1_load) begin
            s1_valid_q <= 1'b1;
            s1_data_q  <= s_data;
            s1_mode_q  <= mode;
        end else if (s2_load) begin
            s1_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_sat_q   <= '0;
        end else if (s2_load) begin
            s2_valid_q <= 1'b1;
            s2_data_q  <= s2_data_d;
            s2_sat_q   <= s2_sat_d;
        end else if (m_ready) begin
            s2_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign m_valid = s2_valid_q;
    assign m_data  = s2_data_q;
    assign m_sat   = s2_sat_q;
    assign sat_cnt = cnt_q;

endmodule
